// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern transmitter.
//   state_t     : FSM state encoding (IDLE/SHIFT/DONE)
//   SEG7_TABLE  : hex digit -> {g,f,e,d,c,b,a} active-high segments
//   eff_len()   : maps a requested pass length onto the legal 1..PAT_W range
package seq_pkg;

    localparam int unsigned LEN_W = 4;
    localparam int unsigned SEG_W = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Entry [15] first: F E d C b A 9 8 7 6 5 4 3 2 1 0
    localparam logic [15:0][SEG_W-1:0] SEG7_TABLE = {
        7'b1110001, 7'b1111001, 7'b1011110, 7'b0111001,
        7'b1111100, 7'b1110111, 7'b1101111, 7'b1111111,
        7'b0000111, 7'b1111101, 7'b1101101, 7'b1100110,
        7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
    };

    // Zero or an oversize request means "the whole pattern register".
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len,
                                                 input logic [LEN_W-1:0] pat_w);
        return ((len == '0) || (len > pat_w)) ? pat_w : len;
    endfunction

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Request/response bundle of the pattern transmitter.
//   master : drives start/pattern/len/loop, observes the serial outputs
//   slave  : the transmitter side
interface seq_pattern_tx_if #(
    parameter int unsigned PAT_W = 8
);
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [3:0]       len;
    logic             loop;
    logic             out;
    logic [2:0]       past;
    logic             busy;
    logic             done;
    logic [6:0]       display;

    modport master (
        output start, pattern, len, loop,
        input  out, past, busy, done, display
    );

    modport slave (
        input  start, pattern, len, loop,
        output out, past, busy, done, display
    );
endinterface

// File: rtl/seg7_decoder.sv
// Hex digit to seven-segment decoder ({g,f,e,d,c,b,a}, active-high).
// Only built when SEQ_TX_DISPLAY_EN is defined.
//   digit : 4-bit value to show
//   seg   : segment drive
`ifdef SEQ_TX_DISPLAY_EN
module seg7_decoder
    import seq_pkg::*;
(
    input  logic [LEN_W-1:0] digit,
    output logic [SEG_W-1:0] seg
);
    assign seg = SEG7_TABLE[digit];
endmodule
`endif

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: latches a pattern on start and shifts it out
// MSB first, one bit per rising edge of the asynchronous clk_aux strobe.
// Optional seven-segment readout of the remaining bit count is enabled by
// defining SEQ_TX_DISPLAY_EN; otherwise display is tied low.
//   osc     : sole clock (rising edge)
//   reset   : synchronous active-low reset
//   clk_aux : asynchronous step strobe
//   bus     : start/pattern/len/loop in; out/past/busy/done/display out
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int unsigned PAT_W = 8
) (
    input  logic             osc,
    input  logic             reset,
    input  logic             clk_aux,
    seq_pattern_tx_if.slave  bus
);

    localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

    state_t           state;
    logic [PAT_W-1:0] shreg;
    logic [PAT_W-1:0] copy_q;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len_q;
    logic             out_q;
    logic [2:0]       past_q;
    logic             busy_q;
    logic             done_q;
    logic             sync1;
    logic             sync2;
    logic             sync2_d;
    logic             step_c;

    // Two-flop synchroniser plus edge-detect delay for clk_aux.
    always_ff @(posedge osc) begin
        if (!reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
        end else begin
            sync1   <= clk_aux;
            sync2   <= sync1;
            sync2_d <= sync2;
        end
    end

    assign step_c = sync2 & ~sync2_d;

    // Transmit FSM with all outputs registered.
    always_ff @(posedge osc) begin
        if (!reset) begin
            state  <= IDLE;
            shreg  <= '0;
            copy_q <= '0;
            cnt    <= '0;
            len_q  <= '0;
            out_q  <= 1'b0;
            past_q <= 3'b000;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    // A step coinciding with start is dropped here.
                    if (bus.start) begin
                        shreg  <= bus.pattern;
                        copy_q <= bus.pattern;
                        cnt    <= eff_len(bus.len, PAT_W_L);
                        len_q  <= eff_len(bus.len, PAT_W_L);
                        busy_q <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (step_c) begin
                        out_q  <= shreg[PAT_W-1];
                        past_q <= {past_q[1:0], shreg[PAT_W-1]};
                        if (cnt == LEN_W'(1)) begin
                            // Pass end: loop is sampled only here.
                            if (bus.loop) begin
                                shreg <= copy_q;
                                cnt   <= len_q;
                            end else begin
                                shreg  <= {shreg[PAT_W-2:0], 1'b0};
                                cnt    <= '0;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                                state  <= DONE;
                            end
                        end else begin
                            shreg <= {shreg[PAT_W-2:0], 1'b0};
                            cnt   <= cnt - LEN_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out  = out_q;
    assign bus.past = past_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

`ifdef SEQ_TX_DISPLAY_EN
    seg7_decoder u_seg7_decoder (
        .digit (cnt),
        .seg   (bus.display)
    );
`else
    assign bus.display = 7'b0000000;
`endif

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: reset, single pass, looping pass,
// restart attempt mid-stream, reset mid-stream, start coinciding with a step.
module tb_seq_pattern_tx;

    logic osc;
    logic reset;
    logic clk_aux;
    int   vectors;
    int   miscompares;
    int   done_cnt;
    int   done_base;

    seq_pattern_tx_if #(.PAT_W(8)) bus ();

    seq_pattern_tx #(.PAT_W(8)) dut (
        .osc     (osc),
        .reset   (reset),
        .clk_aux (clk_aux),
        .bus     (bus)
    );

    initial osc = 1'b0;
    always #5 osc = ~osc;

    always @(posedge osc) if (bus.done === 1'b1) done_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Hand-written segment values for the digits this bench reaches.
    function automatic logic [6:0] exp_disp(input int c);
`ifdef SEQ_TX_DISPLAY_EN
        case (c)
            0:       return 7'b0111111;
            7:       return 7'b0000111;
            8:       return 7'b1111111;
            default: return 7'bxxxxxxx;
        endcase
`else
        return 7'b0000000;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clk_aux pulse: high 4 osc cycles, low 4; output settles within it.
    task automatic aux_step();
        @(negedge osc) clk_aux = 1'b1;
        repeat (4) @(negedge osc);
        clk_aux = 1'b0;
        repeat (4) @(negedge osc);
    endtask

    task automatic pulse_start();
        @(negedge osc) bus.start = 1'b1;
        @(negedge osc) bus.start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge osc) reset = 1'b0;
        @(negedge osc) reset = 1'b1;
    endtask

    logic [7:0] exp29;
    logic [8:0] exp30;

    initial begin
        vectors     = 0;
        miscompares = 0;
        done_cnt    = 0;
        reset       = 1'b0;
        clk_aux     = 1'b0;
        bus.start   = 1'b0;
        bus.pattern = 8'h00;
        bus.len     = 4'd0;
        bus.loop    = 1'b0;
        exp29       = 8'b1011_0100;
        exp30       = 9'b101_101_101;
        repeat (3) @(negedge osc);
        reset = 1'b1;

        // Reset state
        check("rst_out",     32'(bus.out),     32'(1'b0));
        check("rst_past",    32'(bus.past),    32'(3'b000));
        check("rst_busy",    32'(bus.busy),    32'(1'b0));
        check("rst_done",    32'(bus.done),    32'(1'b0));
        check("rst_display", 32'(bus.display), 32'(exp_disp(0)));

        // Single pass, len=0 -> 8 bits
        bus.pattern = 8'b1011_0100;
        bus.len     = 4'd0;
        bus.loop    = 1'b0;
        done_base   = done_cnt;
        pulse_start();
        check("p1_busy_start", 32'(bus.busy),    32'(1'b1));
        check("p1_disp_start", 32'(bus.display), 32'(exp_disp(8)));
        for (int i = 0; i < 8; i++) begin
            aux_step();
            check($sformatf("p1_bit%0d", i), 32'(bus.out), 32'(exp29[7-i]));
            if (i == 0) check("p1_disp_step1", 32'(bus.display), 32'(exp_disp(7)));
            if (i == 6) check("p1_done_early", 32'(done_cnt - done_base), 32'(0));
        end
        check("p1_done_once", 32'(done_cnt - done_base), 32'(1));
        check("p1_past",      32'(bus.past),             32'(3'b100));
        check("p1_busy_end",  32'(bus.busy),             32'(1'b0));
        check("p1_disp_end",  32'(bus.display),          32'(exp_disp(0)));
        aux_step();
        check("p1_out_hold",  32'(bus.out),              32'(1'b0));

        // Looping pass of 3 bits, loop dropped after 7 steps
        bus.pattern = 8'b1010_0000;
        bus.len     = 4'd3;
        bus.loop    = 1'b1;
        done_base   = done_cnt;
        pulse_start();
        for (int i = 0; i < 9; i++) begin
            aux_step();
            check($sformatf("p2_bit%0d", i), 32'(bus.out), 32'(exp30[8-i]));
            if (i == 6) begin
                check("p2_busy_loop", 32'(bus.busy),             32'(1'b1));
                check("p2_no_done",   32'(done_cnt - done_base), 32'(0));
                bus.loop = 1'b0;
            end
        end
        check("p2_done_once", 32'(done_cnt - done_base), 32'(1));
        check("p2_busy_end",  32'(bus.busy),             32'(1'b0));

        // Restart attempt with 8'hFF during transmission is ignored
        bus.pattern = 8'b1011_0100;
        bus.len     = 4'd0;
        done_base   = done_cnt;
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            aux_step();
            check($sformatf("p3_bit%0d", i), 32'(bus.out), 32'(exp29[7-i]));
            if (i == 2) begin
                bus.pattern = 8'hFF;
                @(negedge osc) bus.start = 1'b1;
                repeat (2) @(negedge osc);
                bus.start = 1'b0;
            end
        end
        check("p3_done_once", 32'(done_cnt - done_base), 32'(1));

        // Reset after the 4th bit aborts the transmission
        bus.pattern = 8'b1011_0100;
        pulse_start();
        for (int i = 0; i < 4; i++) aux_step();
        check("p4_bit3", 32'(bus.out), 32'(1'b1));
        do_reset();
        check("p4_rst_out",  32'(bus.out),     32'(1'b0));
        check("p4_rst_past", 32'(bus.past),    32'(3'b000));
        check("p4_rst_busy", 32'(bus.busy),    32'(1'b0));
        check("p4_rst_done", 32'(bus.done),    32'(1'b0));
        check("p4_rst_disp", 32'(bus.display), 32'(exp_disp(0)));
        aux_step();
        aux_step();
        check("p4_out_after", 32'(bus.out),  32'(1'b0));
        check("p4_busy_after", 32'(bus.busy), 32'(1'b0));

        // Start accepted in the same cycle as a step: that step is dropped
        bus.pattern = 8'b1011_0100;
        @(negedge osc) clk_aux = 1'b1;
        @(negedge osc);
        @(negedge osc) bus.start = 1'b1;
        @(negedge osc) bus.start = 1'b0;
        repeat (2) @(negedge osc);
        clk_aux = 1'b0;
        repeat (4) @(negedge osc);
        check("p5_dropped_out",  32'(bus.out),     32'(1'b0));
        check("p5_busy",         32'(bus.busy),    32'(1'b1));
        check("p5_disp",         32'(bus.display), 32'(exp_disp(8)));
        aux_step();
        check("p5_first_bit",    32'(bus.out),     32'(1'b1));
        check("p5_past",         32'(bus.past),    32'(3'b001));
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 SHALL have parameter PAT_W, default 8, meaning pattern register width in bits (legal range 2..15).
REQ-002 SHALL have port osc, input, 1, the only clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-low reset sampled on the osc rising edge.
REQ-004 SHALL have port clk_aux, input, 1: asynchronous step strobe; each rising edge advances transmission by one bit.
REQ-005 SHALL have port start, input, 1: level request to begin a transmission.
REQ-006 SHALL have port pattern, input, PAT_W: bits to transmit, MSB first.
REQ-007 SHALL have port len, input, 4: number of bits per pass; 0 or any value above PAT_W means PAT_W.
REQ-008 SHALL have port loop, input, 1: repeat the pattern continuously while high.
REQ-009 SHALL have port out, output, 1: registered serial bit stream to the sequence recognizer.
REQ-010 SHALL have port past, output, 3: last three transmitted bits, newest in bit 0.
REQ-011 SHALL have port busy, output, 1: high while in state SHIFT.
REQ-012 SHALL have port done, output, 1: one-osc-cycle pulse at the end of a non-looping transmission.
REQ-013 SHALL have port display, output, 7: seven-segment value {g,f,e,d,c,b,a}, active-high.

Function
REQ-014 SHALL synchronise clk_aux through two flops and generate step, a one-cycle pulse on a 0->1 transition of the second flop.
REQ-015 SHALL update out and past on the 3rd osc rising edge after the first edge that samples clk_aux high.
REQ-016 SHALL implement FSM IDLE, SHIFT, DONE.
REQ-017 IDLE: on start=1, SHALL latch pattern into the shift register and a copy register, set cnt to the effective len, and go to SHIFT; busy rises on the next cycle.
REQ-018 SHIFT, on step: out <= shreg MSB; past <= {past[1:0], shreg MSB}; shreg shifts left by 1; cnt decrements by 1.
REQ-019 SHIFT, when the step that makes cnt 0 occurs: if loop=1, reload shreg from the copy register, set cnt to the effective len, and stay in SHIFT; else go to DONE.
REQ-020 DONE SHALL last exactly one cycle with done=1 and then return to IDLE.
REQ-021 start SHALL be ignored in SHIFT and in DONE; pattern, len and loop changes SHALL take effect only at the next latch, except that loop is sampled at each pass end.
REQ-022 step arriving in IDLE or DONE SHALL be ignored; a step coinciding with an accepted start SHALL be dropped, so the first bit is sent on the following step.
REQ-023 out SHALL hold its last transmitted value through DONE and IDLE until the next transmitted bit.
REQ-024 display SHALL show cnt as a hex digit 0-F in all states (cnt is 0 in IDLE).

Reset
REQ-025 With reset=0 at an osc edge, SHALL force: state IDLE, out=0, past=3'b000, busy=0, done=0, cnt=0, shreg and copy register =0, sync flops =0, display = digit 0 (7'b0111111); this overrides any in-progress transmission.

Configuration
REQ-026 With macro SEQ_TX_DISPLAY_EN defined, SHALL drive display from the cnt decoder; without it, SHALL tie display to 7'b0000000 and omit the decoder.

Structure
REQ-027 SHALL place the FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the hex-to-segment table constants in shared package seq_pkg.
REQ-028 SHALL instantiate one sub-module, seg7_decoder (4-bit in, 7-bit out), only under SEQ_TX_DISPLAY_EN.

Verification
REQ-029 pattern=8'b1011_0100, len=0, loop=0, start pulse, 8 clk_aux edges -> out 1,0,1,1,0,1,0,0; done pulses once after the 8th step; past=3'b100; busy falls.
REQ-030 pattern=8'b1010_0000, len=3, loop=1, 7 steps, then loop=0, 2 more steps -> out 1,0,1,1,0,1,1,0,1; done after the 9th step.
REQ-031 Reset low for one cycle after the 4th bit of REQ-029 -> all outputs at their reset values next cycle; further clk_aux edges leave out=0.
REQ-032 start re-asserted with pattern=8'hFF mid-transmission of REQ-029 -> stream unchanged, still 1,0,1,1,0,1,0,0.
REQ-033 With SEQ_TX_DISPLAY_EN: display=7'b1111111 right after start with len=8, and 7'b0000111 after the 1st step; without the macro, display=0 throughout.
REQ-034 start asserted in the same cycle as a step -> no bit sent on that step; first bit 1 appears on the next step.
